// File: rtl/line_assembler_pkg.sv
// -----------------------------------------------------------------------------
// line_assembler_pkg
// Shared definitions for the D5M line assembler and the line-transmit stage
// that consumes its output.
//   COL / ROW     : pixels per line (line buffer depth) / max published rows
//   IDX_W / PIX_W : row/column index width, pixel width
//   pixel_t       : one 16-bit pixel
//   line_t        : one full line as an unpacked array of pixels
//   asm_state_t   : assembler FSM state
// -----------------------------------------------------------------------------
package line_assembler_pkg;

   localparam int COL   = 800;
   localparam int ROW   = 600;
   localparam int IDX_W = 10;
   localparam int PIX_W = 16;

   // Index-width copies so counter comparisons stay width-matched.
   localparam logic [IDX_W-1:0] COL_IDX = IDX_W'(COL);
   localparam logic [IDX_W-1:0] ROW_IDX = IDX_W'(ROW);

   typedef logic [PIX_W-1:0] pixel_t;
   typedef logic [IDX_W-1:0] idx_t;
   typedef pixel_t line_t [COL];

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_LINE = 2'd1,
      ST_FILL      = 2'd2
   } asm_state_t;

endpackage

// File: rtl/line_assembler_bank.sv
// -----------------------------------------------------------------------------
// line_bank
// One COL x 16 register bank. Written one pixel per clock at an address,
// read as a whole line through a full-array port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   addr  : write address (writes at addr >= COL are ignored)
//   wdata : pixel to write
//   data  : entire bank contents
// -----------------------------------------------------------------------------
module line_bank
   import line_assembler_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  logic [PIX_W-1:0] wdata,
   output logic [PIX_W-1:0] data [COL]
);

   always_ff @(posedge clk) begin
      if (we && (addr < COL_IDX)) begin
         data[addr] <= wdata;
      end
   end

endmodule

// File: rtl/line_assembler.sv
// -----------------------------------------------------------------------------
// line_assembler
// Assembles D5M capture rows into full COL-pixel lines using two ping-pong
// banks. The presented bank is held stable while omLineReady is high; the
// other bank fills. A complete line that finishes while the presented line is
// still unconsumed is kept waiting in the fill bank and presented on the next
// ack; any further complete line in that situation is dropped (omOverrun).
//
// Ports
//   imSysClock  : clock            imRST_N    : sync active-low reset
//   imFVAL      : frame valid      imLVAL     : line valid
//   imPixValid  : pixel strobe     imPixel    : pixel data
//   imLineAck   : consumer ack pulse
//   omLine      : presented bank (full line)
//   omLineReady : presented bank holds an unconsumed line
//   omRowIndex  : row number of the presented line
//   omShortLine : one-cycle pulse, line had fewer than COL pixels
//   omOverrun   : sticky, complete line dropped (cleared on imFVAL rise)
//   dbg_state   : current FSM state
//
// Handshake: omLineReady high means omLine/omRowIndex are valid and frozen.
// The consumer pulses imLineAck for one cycle to release the line; an ack
// while omLineReady is low is ignored. If a new line is published on the ack
// edge, omLineReady stays high and the new bank is presented immediately.
// -----------------------------------------------------------------------------
module line_assembler
   import line_assembler_pkg::*;
(
   input  logic             imSysClock,
   input  logic             imRST_N,
   input  logic             imFVAL,
   input  logic             imLVAL,
   input  logic             imPixValid,
   input  logic [PIX_W-1:0] imPixel,
   input  logic             imLineAck,
   output logic [PIX_W-1:0] omLine [COL],
   output logic             omLineReady,
   output logic [IDX_W-1:0] omRowIndex,
   output logic             omShortLine,
   output logic             omOverrun,
   output asm_state_t       dbg_state
);

   asm_state_t       state;
   logic             fval_q;
   logic [IDX_W-1:0] col;
   logic [IDX_W-1:0] row;
   logic             sel;        // presented bank; the fill bank is ~sel
   logic             pending;    // fill bank holds a complete line awaiting ack
   logic [IDX_W-1:0] pend_row;
   logic             doomed;     // current line started with no free bank

   logic             pix_ok;
   logic             line_start;
   logic             line_body;
   logic             line_end;
   logic             line_full;
   logic             line_short;
   logic             row_ok;
   logic             ack_ok;
   logic             store_ok;
   logic             publish;
   logic             hold;
   logic             wr_blocked;
   logic             wr_en;
   logic [IDX_W-1:0] wr_addr;
   logic             we0;
   logic             we1;

   logic [PIX_W-1:0] bank0_data [COL];
   logic [PIX_W-1:0] bank1_data [COL];

   assign pix_ok     = imFVAL && imLVAL && imPixValid;
   // The pixel present on the edge that opens a line belongs to column 0.
   assign line_start = (state == ST_WAIT_LINE) && imFVAL && imLVAL;
   assign line_body  = (state == ST_FILL) && imFVAL && imLVAL;
   assign line_end   = (state == ST_FILL) && imFVAL && !imLVAL;
   assign line_full  = line_end && (col == COL_IDX);
   assign line_short = line_end && (col != COL_IDX);
   assign row_ok     = row < ROW_IDX;
   assign ack_ok     = imLineAck && omLineReady;
   assign store_ok   = line_full && row_ok && !doomed;
   assign publish    = store_ok && (!omLineReady || ack_ok);
   assign hold       = store_ok && omLineReady && !ack_ok;

   // While a waiting line occupies the fill bank, nothing may overwrite it.
   assign wr_blocked = line_start ? pending : doomed;
   assign wr_addr    = line_start ? '0 : col;
   assign wr_en      = pix_ok && (line_start || line_body) && !wr_blocked &&
                       (wr_addr < COL_IDX);
   assign we0        = wr_en && sel;
   assign we1        = wr_en && !sel;

   line_bank u_bank0 (
      .clk   (imSysClock),
      .we    (we0),
      .addr  (wr_addr),
      .wdata (imPixel),
      .data  (bank0_data)
   );

   line_bank u_bank1 (
      .clk   (imSysClock),
      .we    (we1),
      .addr  (wr_addr),
      .wdata (imPixel),
      .data  (bank1_data)
   );

   for (genvar g = 0; g < COL; g++) begin : g_line_mux
      assign omLine[g] = sel ? bank1_data[g] : bank0_data[g];
   end

   assign dbg_state = state;

   always_ff @(posedge imSysClock) begin
      if (!imRST_N) begin
         state       <= ST_IDLE;
         // Treat FVAL as already high so a frame in progress at reset is
         // skipped until a genuine rising edge.
         fval_q      <= 1'b1;
         col         <= '0;
         row         <= '0;
         sel         <= 1'b0;
         pending     <= 1'b0;
         pend_row    <= '0;
         doomed      <= 1'b0;
         omLineReady <= 1'b0;
         omRowIndex  <= '0;
         omShortLine <= 1'b0;
         omOverrun   <= 1'b0;
      end else begin
         fval_q      <= imFVAL;
         omShortLine <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (imFVAL && !fval_q) begin
                  state     <= ST_WAIT_LINE;
                  row       <= '0;
                  omOverrun <= 1'b0;
               end
            end
            ST_WAIT_LINE: begin
               if (!imFVAL) begin
                  state <= ST_IDLE;
               end else if (imLVAL) begin
                  state  <= ST_FILL;
                  doomed <= pending;
                  col    <= IDX_W'(pix_ok);
               end
            end
            ST_FILL: begin
               if (!imFVAL) begin
                  state <= ST_IDLE;
               end else if (!imLVAL) begin
                  state <= ST_WAIT_LINE;
                  if (line_short) begin
                     omShortLine <= 1'b1;
                  end
                  if (line_full && row_ok) begin
                     row <= row + IDX_W'(1);
                     if (doomed) begin
                        omOverrun <= 1'b1;
                     end
                  end
               end else if (pix_ok && (col < COL_IDX)) begin
                  col <= col + IDX_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Presentation: publish a fresh line, promote a waiting line on
         // ack, or release the presented line on ack.
         if (publish) begin
            sel         <= ~sel;
            omLineReady <= 1'b1;
            omRowIndex  <= row;
         end else if (ack_ok && pending) begin
            sel        <= ~sel;
            omRowIndex <= pend_row;
            pending    <= 1'b0;
         end else if (ack_ok) begin
            omLineReady <= 1'b0;
         end

         if (hold) begin
            pending  <= 1'b1;
            pend_row <= row;
         end
      end
   end

endmodule

// File: tb/tb_line_assembler.sv
// -----------------------------------------------------------------------------
// tb_line_assembler
// Directed bench for line_assembler with a line-level reference model and a
// per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_line_assembler;
   import line_assembler_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic             clk;
   logic             rst_n;
   logic             fval;
   logic             lval;
   logic             pixval;
   logic             ack;
   logic [PIX_W-1:0] pixel;
   logic [PIX_W-1:0] line_out [COL];
   logic             ready;
   logic [IDX_W-1:0] row_index;
   logic             short_p;
   logic             overrun;
   asm_state_t       dbg_state;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   line_assembler dut (
      .imSysClock  (clk),
      .imRST_N     (rst_n),
      .imFVAL      (fval),
      .imLVAL      (lval),
      .imPixValid  (pixval),
      .imPixel     (pixel),
      .imLineAck   (ack),
      .omLine      (line_out),
      .omLineReady (ready),
      .omRowIndex  (row_index),
      .omShortLine (short_p),
      .omOverrun   (overrun),
      .dbg_state   (dbg_state)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (line level) ----------------
   bit m_valid = 1'b0;
   bit m_in_frame, m_in_line, m_bad, m_fval_prev;
   bit m_ready, m_short, m_overrun, m_pend;
   int m_row, m_row_idx, m_pend_row;
   int cur_q[$];
   int m_line [COL];
   int m_pend_line [COL];

   always @(posedge clk) begin
      bit ack_ok;
      bit done;
      bit published;
      if (!rst_n) begin
         m_valid = 1'b1; m_in_frame = 1'b0; m_in_line = 1'b0; m_bad = 1'b0;
         m_fval_prev = 1'b1; m_ready = 1'b0; m_short = 1'b0; m_overrun = 1'b0;
         m_pend = 1'b0; m_row = 0; m_row_idx = 0; m_pend_row = 0;
         cur_q.delete();
      end else if (m_valid) begin
         ack_ok = ack && m_ready;
         done = 1'b0;
         published = 1'b0;
         m_short = 1'b0;
         if (!fval) begin
            m_in_frame = 1'b0;
            m_in_line  = 1'b0;
         end else if (!m_in_frame) begin
            if (!m_fval_prev) begin
               m_in_frame = 1'b1; m_row = 0; m_overrun = 1'b0;
            end
         end else if (lval) begin
            if (!m_in_line) begin
               m_in_line = 1'b1;
               m_bad = m_pend;          // no free bank for this line
               cur_q.delete();
            end
            if (pixval) cur_q.push_back(int'(pixel));
         end else if (m_in_line) begin
            m_in_line = 1'b0;
            done = 1'b1;
         end
         if (done) begin
            if (cur_q.size() < COL) begin
               m_short = 1'b1;
            end else if (m_row < ROW) begin
               if (m_bad) begin
                  m_overrun = 1'b1;
               end else if (!m_ready || ack_ok) begin
                  for (int i = 0; i < COL; i++) m_line[i] = cur_q[i];
                  m_ready = 1'b1; m_row_idx = m_row; published = 1'b1;
               end else begin
                  for (int i = 0; i < COL; i++) m_pend_line[i] = cur_q[i];
                  m_pend = 1'b1; m_pend_row = m_row;
               end
               m_row++;
            end
         end
         if (ack_ok && !published) begin
            if (m_pend) begin
               m_line = m_pend_line; m_row_idx = m_pend_row; m_pend = 1'b0;
            end else begin
               m_ready = 1'b0;
            end
         end
         m_fval_prev = fval;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         int bad_n;
         int bad_i;
         chk("ready", int'(ready), int'(m_ready));
         chk("short_pulse", int'(short_p), int'(m_short));
         chk("overrun", int'(overrun), int'(m_overrun));
         if (m_ready) begin
            chk("row_index", int'(row_index), m_row_idx);
            bad_n = 0;
            bad_i = 0;
            for (int i = 0; i < COL; i++) begin
               if (int'(line_out[i]) != m_line[i]) begin
                  if (bad_n == 0) bad_i = i;
                  bad_n++;
               end
            end
            checks++;
            if (bad_n != 0) begin
               errors++;
               $display("FAIL line_data: %0d words differ, first [%0d] got %0d expected %0d",
                        bad_n, bad_i, int'(line_out[bad_i]), m_line[bad_i]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic frame_start();
      fval = 1'b0; lval = 1'b0; pixval = 1'b0;
      @(negedge clk);
      fval = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic frame_end();
      fval = 1'b0; lval = 1'b0; pixval = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_partial(input int base, input int n);
      for (int c = 0; c < n; c++) begin
         lval = 1'b1; pixval = 1'b1; pixel = 16'(base + c);
         @(negedge clk);
      end
   endtask

   // Sends n pixels then one line-end sample; returns one cycle after the
   // line-end edge, so publish results are already visible.
   task automatic send_line(input int base, input int n, input bit ack_end);
      send_partial(base, n);
      lval = 1'b0; pixval = 1'b0; ack = ack_end;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int exp_last [3] = '{799, 1799, 2799};

   initial begin
      rst_n = 1'b0; fval = 1'b0; lval = 1'b0; pixval = 1'b0; ack = 1'b0;
      pixel = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", int'(ready), 0);
      chk("rst_row_index", int'(row_index), 0);
      chk("rst_short", int'(short_p), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_state", int'(dbg_state), int'(ST_IDLE));

      // Three full lines, each acked two cycles after ready.
      frame_start();
      for (int r = 0; r < 3; r++) begin
         send_line(r * 1000, COL, 1'b0);
         chk("t1_ready", int'(ready), 1);
         chk("t1_row_index", int'(row_index), r);
         chk("t1_last_pixel", int'(line_out[799]), exp_last[r]);
         @(negedge clk);
         ack_pulse();
         chk("t1_ack_clear", int'(ready), 0);
         @(negedge clk);
      end
      chk("t1_overrun", int'(overrun), 0);
      frame_end();

      // Short line, then a full line reusing row 0; then an 805-pixel line.
      frame_start();
      send_line(0, 799, 1'b0);
      chk("t2_short_pulse", int'(short_p), 1);
      chk("t2_no_ready", int'(ready), 0);
      @(negedge clk);
      chk("t2_short_once", int'(short_p), 0);
      send_line(5000, COL, 1'b0);
      chk("t2_row_index", int'(row_index), 0);
      chk("t2_first", int'(line_out[0]), 5000);
      chk("t2_last", int'(line_out[799]), 5799);
      ack_pulse();
      send_line(6000, 805, 1'b0);
      chk("t3_row_index", int'(row_index), 1);
      chk("t3_first", int'(line_out[0]), 6000);
      chk("t3_last", int'(line_out[799]), 6799);
      ack_pulse();
      frame_end();

      // No ack across three lines: second waits, third is dropped.
      frame_start();
      send_line(10000, COL, 1'b0);
      send_line(11000, COL, 1'b0);
      chk("t4_held_row", int'(row_index), 0);
      chk("t4_held_first", int'(line_out[0]), 10000);
      chk("t4_no_overrun", int'(overrun), 0);
      send_line(12000, COL, 1'b0);
      chk("t4_overrun", int'(overrun), 1);
      chk("t4_still_held", int'(line_out[799]), 10799);
      ack_pulse();
      chk("t4_promoted_ready", int'(ready), 1);
      chk("t4_promoted_row", int'(row_index), 1);
      chk("t4_promoted_first", int'(line_out[0]), 11000);
      chk("t4_promoted_last", int'(line_out[799]), 11799);
      ack_pulse();
      chk("t4_released", int'(ready), 0);
      frame_end();
      chk("t4_overrun_sticky", int'(overrun), 1);
      frame_start();
      chk("t4_overrun_cleared", int'(overrun), 0);

      // Ack on the same edge as a line end.
      send_line(20000, COL, 1'b0);
      chk("t5_row0", int'(row_index), 0);
      send_line(21000, COL, 1'b1);
      chk("t5_ready_kept", int'(ready), 1);
      chk("t5_row1", int'(row_index), 1);
      chk("t5_switched", int'(line_out[0]), 21000);
      ack_pulse();
      frame_end();

      // FVAL falls at pixel 400: silent abort.
      frame_start();
      send_partial(40000, 400);
      fval = 1'b0; lval = 1'b0; pixval = 1'b0;
      @(negedge clk);
      chk("t6_abort_short", int'(short_p), 0);
      chk("t6_abort_state", int'(dbg_state), int'(ST_IDLE));
      repeat (2) @(negedge clk);
      chk("t6_abort_ready", int'(ready), 0);

      // Busy frame, then reset mid-line.
      frame_start();
      send_line(50000, COL, 1'b0);
      send_line(51000, COL, 1'b0);
      send_line(52000, COL, 1'b0);
      chk("t6_pre_overrun", int'(overrun), 1);
      send_partial(53000, 300);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_ready", int'(ready), 0);
      chk("t6_rst_row_index", int'(row_index), 0);
      chk("t6_rst_short", int'(short_p), 0);
      chk("t6_rst_overrun", int'(overrun), 0);
      chk("t6_rst_state", int'(dbg_state), int'(ST_IDLE));
      rst_n = 1'b1; lval = 1'b0; pixval = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_no_false_rise", int'(dbg_state), int'(ST_IDLE));
      frame_start();
      send_line(60000, COL, 1'b0);
      chk("t6_restart_row", int'(row_index), 0);
      chk("t6_restart_first", int'(line_out[0]), 60000);
      chk("t6_restart_last", int'(line_out[799]), 60799);
      ack_pulse();
      frame_end();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
